main_fsm: RTL and testbench

Moore control state machine that sequences the shared multicycle datapath (one ALU, one unified memory port, one register file) through fetch, decode and execute steps. It takes the instruction class fields from the instruction register and drives the datapath multiplexer selects and write enables. It also drives the `ALUOp` input of the ALU decoder. The conditional-execution logic gates `RegW`, `MemW`, `NextPC` and `Branch` downstream of this block.

---
 rtl/main_fsm.sv | 199 +++++++++++++++++++
 tb/tb_main_fsm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute and drives datapath selects.
// Optional MAIN_FSM_MEM_WAIT_EN adds a MemReady handshake on the memory-access states.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
`ifdef MAIN_FSM_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       InstrDone,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMREAD = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        UNDEF   = 4'd10
    } state_t;

    localparam logic [SEL_W-1:0] SRCB_REG = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_4   = 2'b10;
    localparam logic [SEL_W-1:0] RES_OUT  = 2'b00;
    localparam logic [SEL_W-1:0] RES_RD   = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALU  = 2'b10;

    state_t           state_q, state_d, tgt_c;
    logic             mem_rdy_c;
    logic             ir_write_q, ir_write_d;
    logic             adr_src_q, adr_src_d;
    logic             alu_src_a_q, alu_src_a_d;
    logic [SEL_W-1:0] alu_src_b_q, alu_src_b_d;
    logic [SEL_W-1:0] result_src_q, result_src_d;
    logic             alu_op_q, alu_op_d;
    logic             next_pc_q, next_pc_d;
    logic             reg_w_q, reg_w_d;
    logic             mem_w_q, mem_w_d;
    logic             branch_q, branch_d;
    logic             instr_done_q, instr_done_d;
    logic             unused_funct_c;

`ifdef MAIN_FSM_MEM_WAIT_EN
    assign mem_rdy_c = MemReady;
`else
    assign mem_rdy_c = 1'b1;
`endif

    assign unused_funct_c = ^Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
        ir_write_q   <= ir_write_d;
        adr_src_q    <= adr_src_d;
        alu_src_a_q  <= alu_src_a_d;
        alu_src_b_q  <= alu_src_b_d;
        result_src_q <= result_src_d;
        alu_op_q     <= alu_op_d;
        next_pc_q    <= next_pc_d;
        reg_w_q      <= reg_w_d;
        mem_w_q      <= mem_w_d;
        branch_q     <= branch_d;
        instr_done_q <= instr_done_d;
    end

    // Next state, then Moore outputs decoded from the state being entered so they register in step.
    always_comb begin
        state_d      = FETCH;
        ir_write_d   = 1'b0;
        adr_src_d    = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = SRCB_REG;
        result_src_d = RES_OUT;
        alu_op_d     = 1'b0;
        next_pc_d    = 1'b0;
        reg_w_d      = 1'b0;
        mem_w_d      = 1'b0;
        branch_d     = 1'b0;
        instr_done_d = 1'b0;

        case (state_q)
            FETCH:   state_d = mem_rdy_c ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNDEF;
                endcase
            end
            MEMADR:  state_d = Funct[0] ? MEMREAD : MEMWR;
            MEMREAD: state_d = mem_rdy_c ? MEMWB : MEMREAD;
            MEMWB:   state_d = FETCH;
            MEMWR:   state_d = mem_rdy_c ? FETCH : MEMWR;
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            UNDEF:   state_d = FETCH;
            default: state_d = FETCH;
        endcase

        tgt_c = reset ? FETCH : state_d;

        case (tgt_c)
            FETCH: begin
                ir_write_d   = 1'b1;
                alu_src_a_d  = 1'b1;
                alu_src_b_d  = SRCB_4;
                result_src_d = RES_ALU;
                next_pc_d    = 1'b1;
            end
            DECODE: begin
                alu_src_a_d  = 1'b1;
                alu_src_b_d  = SRCB_4;
                result_src_d = RES_ALU;
            end
            MEMADR: begin
                alu_src_b_d  = SRCB_IMM;
            end
            MEMREAD: begin
                adr_src_d    = 1'b1;
            end
            MEMWB: begin
                result_src_d = RES_RD;
                reg_w_d      = 1'b1;
                instr_done_d = 1'b1;
            end
            MEMWR: begin
                adr_src_d    = 1'b1;
                mem_w_d      = 1'b1;
                instr_done_d = 1'b1;
            end
            EXECR: begin
                alu_src_b_d  = SRCB_REG;
                alu_op_d     = 1'b1;
            end
            EXECI: begin
                alu_src_b_d  = SRCB_IMM;
                alu_op_d     = 1'b1;
            end
            ALUWB: begin
                reg_w_d      = 1'b1;
                instr_done_d = 1'b1;
            end
            BRANCH: begin
                alu_src_b_d  = SRCB_IMM;
                result_src_d = RES_ALU;
                branch_d     = 1'b1;
                instr_done_d = 1'b1;
            end
            UNDEF: begin
                instr_done_d = 1'b1;
            end
            default: begin
                instr_done_d = 1'b0;
            end
        endcase
    end

    assign IRWrite   = ir_write_q;
    assign AdrSrc    = adr_src_q;
    assign ALUSrcA   = alu_src_a_q;
    assign ALUSrcB   = alu_src_b_q;
    assign ResultSrc = result_src_q;
    assign ALUOp     = alu_op_q;
    assign NextPC    = next_pc_q;
    assign RegW      = reg_w_q;
    assign MemW      = mem_w_q;
    assign Branch    = branch_q;
    assign InstrDone = instr_done_q;
    assign State     = STATE_W'(state_q);

endmodule

// File: tb/tb_main_fsm.sv
// Directed self-checking bench for main_fsm: per-instruction state walks and key outputs.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite, AdrSrc, ALUSrcA, ALUOp, NextPC, RegW, MemW, Branch, InstrDone;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] State;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
`ifdef MAIN_FSM_MEM_WAIT_EN
        .MemReady  (mem_ready),
`endif
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .InstrDone (InstrDone),
        .State     (State)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and check retire never overlaps fetch.
    task automatic step();
        @(posedge clk);
        #1;
        check("done_vs_irwrite", 8'(IRWrite & InstrDone), 8'd0);
    endtask

    task automatic check_fetch(input string tag);
        check({tag, "_state"}, 8'(State), 8'd0);
        check({tag, "_outs"},
              8'({IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}),
              8'b1_0_1_10_10_0);
        check({tag, "_wr"}, 8'({NextPC, RegW, MemW, Branch, InstrDone}), 8'b10000);
    endtask

    initial begin
        reset = 1'b1;
        Op = 2'b00;
        Funct = 6'b000000;
        mem_ready = 1'b1;
        #2;
        step();
        step();
        check_fetch("reset_hold");

        // Register ADD
        reset = 1'b0;
        Funct = 6'b001000;
        step(); check("add_s1", 8'(State), 8'd1);
        check("add_dec", 8'({ALUSrcA, ALUSrcB, ResultSrc, IRWrite}), 8'b1_10_10_0);
        step(); check("add_s6", 8'(State), 8'd6);
        check("add_aluop", 8'({ALUOp, ALUSrcA, ALUSrcB}), 8'b1_0_00);
        step(); check("add_s8", 8'(State), 8'd8);
        check("add_wb", 8'({RegW, InstrDone, ResultSrc}), 8'b1_1_00);
        step(); check_fetch("add_end");

        // Immediate LDR
        Op = 2'b01; Funct = 6'b011001;
        step(); check("ldr_s1", 8'(State), 8'd1);
        step(); check("ldr_s2", 8'(State), 8'd2);
        check("ldr_adr", 8'({ALUSrcA, ALUSrcB, ALUOp}), 8'b0_01_0);
        step(); check("ldr_s3", 8'(State), 8'd3);
        check("ldr_rd", 8'({AdrSrc, ResultSrc, RegW, InstrDone}), 8'b1_00_0_0);
        step(); check("ldr_s4", 8'(State), 8'd4);
        check("ldr_wb", 8'({ResultSrc, RegW, InstrDone, MemW}), 8'b01_1_1_0);
        step(); check_fetch("ldr_end");

        // STR
        Funct = 6'b011000;
        step(); check("str_s1", 8'(State), 8'd1);
        check("str_memw1", 8'(MemW), 8'd0);
        step(); check("str_s2", 8'(State), 8'd2);
        check("str_memw2", 8'(MemW), 8'd0);
        step(); check("str_s5", 8'(State), 8'd5);
        check("str_wr", 8'({MemW, AdrSrc, InstrDone, RegW}), 8'b1_1_1_0);
        step(); check_fetch("str_end");

        // Branch
        Op = 2'b10; Funct = 6'b000000;
        step(); check("b_s1", 8'(State), 8'd1);
        step(); check("b_s9", 8'(State), 8'd9);
        check("b_outs", 8'({Branch, ALUSrcA, ALUSrcB, ResultSrc, InstrDone}), 8'b1_0_01_10_1);
        step(); check_fetch("b_end");

        // Undefined
        Op = 2'b11;
        step(); check("u_s1", 8'(State), 8'd1);
        check("u_nowr1", 8'({RegW, MemW, Branch}), 8'd0);
        step(); check("u_s10", 8'(State), 8'd10);
        check("u_outs", 8'({IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp}), 8'd0);
        check("u_wr", 8'({NextPC, RegW, MemW, Branch, InstrDone}), 8'b00001);
        step(); check_fetch("u_end");

        // Immediate data-processing
        Op = 2'b00; Funct = 6'b100000;
        step(); check("dpi_s1", 8'(State), 8'd1);
        step(); check("dpi_s7", 8'(State), 8'd7);
        check("dpi_outs", 8'({ALUOp, ALUSrcA, ALUSrcB}), 8'b1_0_01);
        step(); check("dpi_s8", 8'(State), 8'd8);
        step(); check_fetch("dpi_end");

        // Reset in the middle of a load
        Op = 2'b01; Funct = 6'b000001;
        step(); step(); step();
        check("mid_s3", 8'(State), 8'd3);
        reset = 1'b1;
        step(); check_fetch("mid_rst1");
        step(); check_fetch("mid_rst2");
        reset = 1'b0;
        step(); check("mid_after", 8'(State), 8'd1);
        step(); step(); step(); step();
        check_fetch("mid_ldr_end");

`ifdef MAIN_FSM_MEM_WAIT_EN
        // FETCH waits on MemReady
        mem_ready = 1'b0;
        step(); check_fetch("wait1");
        step(); check_fetch("wait2");
        step(); check_fetch("wait3");
        mem_ready = 1'b1;
        step(); check("wait_adv", 8'(State), 8'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
